// File: rtl/lcd_vram_scanout.sv
// Text-mode LCD scanout: walks the panel raster, fetches a character code from
// VRAM and a glyph row from the font ROM for every pixel, and drives RGB565
// panel signals with a fixed four-clock pipeline latency.
module lcd_vram_scanout #(
  parameter int unsigned H_ACTIVE = 480,
  parameter int unsigned H_FP     = 2,
  parameter int unsigned H_SYNC   = 41,
  parameter int unsigned H_BP     = 2,
  parameter int unsigned V_ACTIVE = 272,
  parameter int unsigned V_FP     = 2,
  parameter int unsigned V_SYNC   = 10,
  parameter int unsigned V_BP     = 2,
  parameter int unsigned COLS     = 60,
  parameter logic [15:0] FG       = 16'hFFFF,
  parameter logic [15:0] BG       = 16'h0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [9:0]  v_adb,
  output logic        v_ceb,
  output logic        v_oce,
  input  logic [7:0]  v_dout,
  output logic [11:0] font_addr,
  input  logic [7:0]  font_data,
  output logic        lcd_de,
  output logic        lcd_hsync,
  output logic        lcd_vsync,
  output logic [4:0]  lcd_r,
  output logic [5:0]  lcd_g,
  output logic [4:0]  lcd_b,
  output logic        vsync
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned HW = $clog2(H_TOTAL);
  localparam int unsigned VW = $clog2(V_TOTAL);

  localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT    = HW'(H_ACTIVE);
  localparam logic [HW-1:0] H_SYNC_S = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] H_SYNC_E = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_ACT    = VW'(V_ACTIVE);
  localparam logic [VW-1:0] V_SYNC_S = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] V_SYNC_E = VW'(V_ACTIVE + V_FP + V_SYNC);

  // run_q is low during reset and on the first post-release edge, so the
  // counters sit at (0,0) for exactly one cycle of fetch before advancing.
  logic          run_q;
  logic [HW-1:0] hcnt_q, hcnt_d;
  logic [VW-1:0] vcnt_q, vcnt_d;
  logic          de_raw, hs_raw, vs_raw;
  logic [9:0]    adb_q;

  // Pipeline tags: index 0 = stage t+1, 1 = t+2, 2 = t+3.
  logic [2:0]    de_p, hs_p, vs_p;
  logic [3:0]    row_p1, row_p2;
  logic [2:0]    bit_p1, bit_p2, bit_p3;
  logic          pixel_on;
  logic [15:0]   colour, colour_q;

  // Raster counter next-state; hcnt wraps into vcnt, vcnt wraps at frame end.
  always_comb begin
    hcnt_d = hcnt_q;
    vcnt_d = vcnt_q;
    if (run_q) begin
      if (hcnt_q == H_LAST) begin
        hcnt_d = '0;
        vcnt_d = (vcnt_q == V_LAST) ? '0 : vcnt_q + VW'(1);
      end else begin
        hcnt_d = hcnt_q + HW'(1);
      end
    end
  end

  assign de_raw = run_q && (hcnt_q < H_ACT) && (vcnt_q < V_ACT);
  assign hs_raw = !((hcnt_q >= H_SYNC_S) && (hcnt_q < H_SYNC_E));
  assign vs_raw = !((vcnt_q >= V_SYNC_S) && (vcnt_q < V_SYNC_E));

  // Cell index fits in 10 bits for any geometry with <= 1024 cells.
  assign v_adb = de_raw ? (10'(vcnt_q >> 4) * 10'(COLS) + 10'(hcnt_q >> 3)) : adb_q;
  assign v_ceb = de_raw;
  assign v_oce = de_raw;

  // Glyph row lookup uses the character code arriving two cycles after fetch.
  assign font_addr = de_p[1] ? {v_dout, row_p2} : '0;

  assign pixel_on = font_data[3'd7 - bit_p3];
  assign colour   = de_p[2] ? (pixel_on ? FG : BG) : '0;

  assign lcd_r = colour_q[15:11];
  assign lcd_g = colour_q[10:5];
  assign lcd_b = colour_q[4:0];

  // Raster counters, run flag and held VRAM address.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_q  <= 1'b0;
      hcnt_q <= '0;
      vcnt_q <= '0;
      adb_q  <= '0;
    end else begin
      run_q  <= 1'b1;
      hcnt_q <= hcnt_d;
      vcnt_q <= vcnt_d;
      adb_q  <= v_adb;
    end
  end

  // Delay line carrying timing and pixel-position tags alongside the fetch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      de_p   <= '0;
      hs_p   <= '1;
      vs_p   <= '1;
      row_p1 <= '0;
      row_p2 <= '0;
      bit_p1 <= '0;
      bit_p2 <= '0;
      bit_p3 <= '0;
    end else begin
      de_p   <= {de_p[1:0], de_raw};
      hs_p   <= {hs_p[1:0], hs_raw};
      vs_p   <= {vs_p[1:0], vs_raw};
      row_p1 <= vcnt_q[3:0];
      row_p2 <= row_p1;
      bit_p1 <= hcnt_q[2:0];
      bit_p2 <= bit_p1;
      bit_p3 <= bit_p2;
    end
  end

  // Registered panel outputs and the CPU frame-wait flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lcd_de    <= 1'b0;
      lcd_hsync <= 1'b1;
      lcd_vsync <= 1'b1;
      colour_q  <= '0;
      vsync     <= 1'b0;
    end else begin
      lcd_de    <= de_p[2];
      lcd_hsync <= hs_p[2];
      lcd_vsync <= vs_p[2];
      colour_q  <= colour;
      // Taken from next-state vcnt so it changes on hcnt 0 of the line.
      vsync     <= (vcnt_d >= V_ACT);
    end
  end

endmodule

// File: tb/tb_lcd_vram_scanout.sv
// Bench for lcd_vram_scanout: small raster geometry, random VRAM/font contents,
// and a position-based reference model of every output.
module tb_lcd_vram_scanout;

  localparam int HA = 40, HF = 2, HS = 5, HB = 3;
  localparam int VA = 36, VF = 2, VS = 3, VB = 2;
  localparam int CL = 5;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int FT = HT * VT;
  localparam int FGC = 'hF800;
  localparam int BGC = 'h07E0;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [9:0]  v_adb;
  logic        v_ceb, v_oce;
  logic [7:0]  v_dout;
  logic [11:0] font_addr;
  logic [7:0]  font_data;
  logic        lcd_de, lcd_hsync, lcd_vsync, vsync;
  logic [4:0]  lcd_r, lcd_b;
  logic [5:0]  lcd_g;

  logic [7:0]  vram [1024];
  logic [7:0]  font [4096];
  logic [9:0]  vaddr_r;
  logic        ce_r;

  int checks = 0;
  int errors = 0;
  int n, last_adb, de_cnt;

  lcd_vram_scanout #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .COLS(CL), .FG(16'hF800), .BG(16'h07E0)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .v_adb(v_adb), .v_ceb(v_ceb), .v_oce(v_oce), .v_dout(v_dout),
    .font_addr(font_addr), .font_data(font_data),
    .lcd_de(lcd_de), .lcd_hsync(lcd_hsync), .lcd_vsync(lcd_vsync),
    .lcd_r(lcd_r), .lcd_g(lcd_g), .lcd_b(lcd_b), .vsync(vsync)
  );

  always #5 clk = ~clk;

  // Two-cycle VRAM: address register, then output register.
  always @(posedge clk) begin
    ce_r <= v_ceb;
    if (v_ceb) vaddr_r <= v_adb;
    if (ce_r) v_dout <= vram[vaddr_r];
  end

  // One-cycle font ROM.
  always @(posedge clk) font_data <= font[font_addr];

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (n=%0d)", tag, obs, exp, n);
    end
  endtask

  function automatic int hof(int p); return p % HT; endfunction
  function automatic int vof(int p); return (p / HT) % VT; endfunction
  function automatic int de_at(int p);
    return (hof(p) < HA && vof(p) < VA) ? 1 : 0;
  endfunction
  function automatic int cell_at(int p);
    return (vof(p) / 16) * CL + hof(p) / 8;
  endfunction
  function automatic int pix_at(int p);
    int g;
    if (de_at(p) == 0) return 0;
    g = int'(font[int'(vram[cell_at(p)]) * 16 + vof(p) % 16]);
    return (((g >> (7 - hof(p) % 8)) & 1) != 0) ? FGC : BGC;
  endfunction

  task automatic check_reset(input string where);
    chk({where, "_lcd_de"}, int'(lcd_de), 0);
    chk({where, "_lcd_hsync"}, int'(lcd_hsync), 1);
    chk({where, "_lcd_vsync"}, int'(lcd_vsync), 1);
    chk({where, "_rgb"}, int'({lcd_r, lcd_g, lcd_b}), 0);
    chk({where, "_vsync"}, int'(vsync), 0);
    chk({where, "_v_ceb"}, int'(v_ceb), 0);
    chk({where, "_v_oce"}, int'(v_oce), 0);
    chk({where, "_v_adb"}, int'(v_adb), 0);
    chk({where, "_font_addr"}, int'(font_addr), 0);
  endtask

  // Advance one clock and compare every output with the raster model.
  // After the n-th post-release edge: fetch shows position n-1, font_addr
  // shows position n-3 and the panel shows position n-5.
  task automatic step();
    int po, pa, pf, h, v, e_ceb, e_adb, e_fa;
    @(posedge clk);
    n++;
    @(negedge clk);
    po = n - 5;
    pa = n - 3;
    pf = n - 1;
    if (lcd_de === 1'b1) de_cnt++;
    if (po < 0) begin
      chk("lcd_de_fill", int'(lcd_de), 0);
      chk("lcd_hsync_fill", int'(lcd_hsync), 1);
      chk("lcd_vsync_fill", int'(lcd_vsync), 1);
      chk("rgb_fill", int'({lcd_r, lcd_g, lcd_b}), 0);
    end else begin
      h = hof(po);
      v = vof(po);
      chk("lcd_de", int'(lcd_de), de_at(po));
      chk("lcd_hsync", int'(lcd_hsync), (h >= HA + HF && h < HA + HF + HS) ? 0 : 1);
      chk("lcd_vsync", int'(lcd_vsync), (v >= VA + VF && v < VA + VF + VS) ? 0 : 1);
      chk("rgb", int'({lcd_r, lcd_g, lcd_b}), pix_at(po));
    end
    e_ceb = de_at(pf);
    e_adb = (e_ceb != 0) ? cell_at(pf) : last_adb;
    last_adb = e_adb;
    chk("v_ceb", int'(v_ceb), e_ceb);
    chk("v_oce", int'(v_oce), e_ceb);
    chk("v_adb", int'(v_adb), e_adb);
    e_fa = (pa >= 0 && de_at(pa) != 0) ? int'(vram[cell_at(pa)]) * 16 + vof(pa) % 16 : 0;
    chk("font_addr", int'(font_addr), e_fa);
    chk("vsync", int'(vsync), (vof(pf) >= VA) ? 1 : 0);
  endtask

  // Hand-derived spot values at known raster positions.
  task automatic spot();
    case (n)
      3:  chk("spot_font_addr_cell0_row0", int'(font_addr), 'h410);
      4:  chk("spot_de_before_latency", int'(lcd_de), 0);
      5:  chk("spot_pix0_fg", int'({lcd_r, lcd_g, lcd_b}), FGC);
      6:  chk("spot_pix1_bg", int'({lcd_r, lcd_g, lcd_b}), BGC);
      12: chk("spot_pix7_fg", int'({lcd_r, lcd_g, lcd_b}), FGC);
      16 * HT + 8 + 1: chk("spot_line16_col8_cell", int'(v_adb), CL + 1);
      (VA - 1) * HT + HA - 1 + 1: chk("spot_last_cell", int'(v_adb), 14);
      default: ;
    endcase
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) vram[i] = 8'($urandom);
    for (int i = 0; i < 4096; i++) font[i] = 8'($urandom);
    vram[0] = 8'h41;
    vram[CL + 1] = 8'h42;
    for (int r = 0; r < 16; r++) font['h410 + r] = 8'h81;

    rst_n = 1'b0;
    n = 0;
    repeat (3) @(negedge clk);
    check_reset("init");

    rst_n = 1'b1;
    n = 0;
    last_adb = 0;
    de_cnt = 0;
    repeat (2 * FT + 4) begin
      step();
      spot();
    end
    chk("de_count_2frames", de_cnt, 2 * HA * VA);

    // Abort the third frame with the fetch at line 20, pixel 25.
    while (n - 1 < 2 * FT + 20 * HT + 25) step();
    #1 rst_n = 1'b0;
    #1 check_reset("async");
    repeat (3) begin
      @(posedge clk);
      @(negedge clk);
      check_reset("hold");
    end

    rst_n = 1'b1;
    n = 0;
    last_adb = 0;
    repeat (FT + 10) begin
      step();
      spot();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
